// File: rtl/ones_pkg.sv
// Shared definitions for the population-count blocks: FSM state encoding and
// the width helper used to size per-chunk popcount results.
package ones_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bits needed to hold a ones count of an n-bit field (0..n inclusive).
  function automatic int pc_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_ones_counter_chunk_popcount.sv
// Combinational ones count of a single CHUNK-bit slice, optionally inverted
// first so the same adder tree serves both ones and zeros counting.
module chunk_popcount
  import ones_pkg::*;
#(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0]            bits,
  input  logic                        invert,
  output logic [pc_width(CHUNK)-1:0]  cnt
);

  localparam int PW = pc_width(CHUNK);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < CHUNK; i++) begin
      cnt = cnt + PW'(bits[i] ^ invert);
    end
  end

endmodule

// File: rtl/seq_ones_counter.sv
// Sequential population counter: latches a WIDTH-bit word on start and counts
// its ones (or zeros) CHUNK bits per cycle, then pulses done with the result.
module seq_ones_counter
  import ones_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int CHUNK = 1,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count
);

  localparam int NCH = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int CCW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = pc_width(CHUNK);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("seq_ones_counter: WIDTH must be within 2..64");
  end
  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("seq_ones_counter: CHUNK must divide WIDTH exactly");
  end

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic             mode_q;
  logic [CW-1:0]    acc;
  logic [CCW-1:0]   chunk_cnt;
  logic [PW-1:0]    pc;
  logic [CW-1:0]    acc_next;

  chunk_popcount #(
    .CHUNK (CHUNK)
  ) u_chunk_popcount (
    .bits   (shift_reg[CHUNK-1:0]),
    .invert (mode_q),
    .cnt    (pc)
  );

  // acc tops out at WIDTH, which CW always holds, so no saturation is needed.
  assign acc_next = acc + CW'(pc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      shift_reg <= '0;
      mode_q    <= 1'b0;
      acc       <= '0;
      chunk_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_COUNT: begin
          acc       <= acc_next;
          shift_reg <= shift_reg >> CHUNK;
          if (chunk_cnt == '0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            count <= acc_next;
          end else begin
            chunk_cnt <= chunk_cnt - CCW'(1);
          end
        end
        // IDLE and DONE both accept a new word; DONE doing so gives back-to-back ops.
        default: begin
          if (start) begin
            shift_reg <= din;
            mode_q    <= mode;
            acc       <= '0;
            chunk_cnt <= CCW'(NCH - 1);
            state     <= ST_COUNT;
            busy      <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ones_counter.sv
// Directed bench for seq_ones_counter: default 8x1, an 8x4 and a 3x1 instance.
module tb_seq_ones_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, mode0, busy0, done0;
  logic [7:0] din0;
  logic [3:0] count0;
  logic       start1, mode1, busy1, done1;
  logic [7:0] din1;
  logic [3:0] count1;
  logic       start2, mode2, busy2, done2;
  logic [2:0] din2;
  logic [1:0] count2;

  int n_checks = 0;
  int n_fail   = 0;

  seq_ones_counter u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .din(din0), .mode(mode0),
    .busy(busy0), .done(done0), .count(count0)
  );

  seq_ones_counter #(.WIDTH(8), .CHUNK(4)) u_dut_c4 (
    .clk(clk), .rst_n(rst_n), .start(start1), .din(din1), .mode(mode1),
    .busy(busy1), .done(done1), .count(count1)
  );

  seq_ones_counter #(.WIDTH(3), .CHUNK(1)) u_dut_w3 (
    .clk(clk), .rst_n(rst_n), .start(start2), .din(din2), .mode(mode2),
    .busy(busy2), .done(done2), .count(count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic s, input logic [7:0] d, input logic m);
    case (sel)
      0:       begin start0 = s; din0 = d;      mode0 = m; end
      1:       begin start1 = s; din1 = d;      mode1 = m; end
      default: begin start2 = s; din2 = d[2:0]; mode2 = m; end
    endcase
  endtask

  task automatic sample(input int sel, output logic b, output logic dn, output logic [3:0] c);
    case (sel)
      0:       begin b = busy0; dn = done0; c = count0; end
      1:       begin b = busy1; dn = done1; c = count1; end
      default: begin b = busy2; dn = done2; c = {2'b00, count2}; end
    endcase
  endtask

  // One operation: start in cycle 0, busy for nch cycles, done in cycle nch+1.
  task automatic run_op(input int sel, input logic [7:0] d, input logic m,
                        input int exp_cnt, input int prev_cnt, input string tag);
    int         nch;
    int         bad_busy = 0;
    int         bad_hold = 0;
    logic       b, dn;
    logic [3:0] c;
    nch = (sel == 0) ? 8 : (sel == 1) ? 2 : 3;
    tick();
    drive(sel, 1'b1, d, m);
    for (int k = 1; k <= nch; k++) begin
      tick();
      if (k == 1) drive(sel, 1'b0, 8'h00, 1'b0);
      sample(sel, b, dn, c);
      if (!b || dn) bad_busy++;
      if (c !== 4'(prev_cnt)) bad_hold++;
    end
    check({tag, "_busy_window"}, bad_busy, 0);
    check({tag, "_count_held"}, bad_hold, 0);
    tick();
    sample(sel, b, dn, c);
    check({tag, "_done"}, dn, 1);
    check({tag, "_busy_at_done"}, b, 0);
    check({tag, "_count"}, c, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tbl[8] = '{0, 1, 1, 2, 1, 2, 2, 3};
    int bad;
    int nd;
    int prev;

    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    drive(2, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    // Start coincident with reset must be dropped.
    drive(0, 1'b1, 8'hFF, 1'b0);
    tick();
    rst_n = 1'b1;
    drive(0, 1'b0, 8'h00, 1'b0);
    check("reset_busy", busy0, 0);
    check("reset_done", done0, 0);
    check("reset_count", count0, 0);
    check("reset_count_c4", count1, 0);
    check("reset_count_w3", count2, 0);
    tick();
    check("start_in_reset_dropped", busy0, 0);

    // Single one bit.
    run_op(0, 8'h40, 1'b0, 1, 0, "t1");
    tick();
    check("t1_done_pulse_width", done0, 0);
    check("t1_count_after_done", count0, 1);

    // Boundary words in both modes.
    run_op(0, 8'hFF, 1'b0, 8, 1, "t2_ff_ones");
    run_op(0, 8'hFF, 1'b1, 0, 8, "t2_ff_zeros");
    run_op(0, 8'h00, 1'b0, 0, 0, "t2_00_ones");
    run_op(0, 8'h00, 1'b1, 8, 0, "t2_00_zeros");

    // Start held high while busy, then back-to-back restart from DONE.
    tick();
    drive(0, 1'b1, 8'h0F, 1'b0);
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      drive(0, 1'b1, 8'hFF, 1'b1);
      if (!busy0 || done0 || count0 !== 4'd8) bad++;
    end
    check("t3_busy_window", bad, 0);
    tick();
    drive(0, 1'b1, 8'hFF, 1'b0);
    check("t3_done", done0, 1);
    check("t3_count", count0, 4);
    bad = 0;
    for (int k = 10; k <= 17; k++) begin
      tick();
      if (k == 10) drive(0, 1'b0, 8'h00, 1'b0);
      if (!busy0 || done0 || count0 !== 4'd4) bad++;
    end
    check("t3_b2b_busy_window", bad, 0);
    tick();
    check("t3_b2b_done", done0, 1);
    check("t3_b2b_count", count0, 8);

    // Abort by reset mid-count.
    tick();
    drive(0, 1'b1, 8'hB3, 1'b0);
    tick();
    drive(0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    check("t4_busy_before_reset", busy0, 1);
    check("t4_count_held", count0, 8);
    tick();
    rst_n = 1'b1;
    check("t4_busy_after_reset", busy0, 0);
    check("t4_done_after_reset", done0, 0);
    check("t4_count_after_reset", count0, 0);
    nd = 0;
    for (int k = 6; k <= 20; k++) begin
      tick();
      if (done0 || busy0) nd++;
    end
    check("t4_no_done_after_abort", nd, 0);

    // Four bits per cycle.
    run_op(1, 8'hA5, 1'b0, 4, 0, "t5_a5_ones");
    run_op(1, 8'hA5, 1'b1, 4, 4, "t5_a5_zeros");
    run_op(1, 8'h7F, 1'b0, 7, 4, "t5_7f_ones");

    // Three-input truth table.
    prev = 0;
    for (int v = 0; v < 8; v++) begin
      run_op(2, 8'(v), 1'b0, tbl[v], prev, $sformatf("t6_din%0d", v));
      prev = tbl[v];
    end
    run_op(2, 8'd5, 1'b1, 1, prev, "t6_din5_zeros");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_ones_counter.md
Name: seq_ones_counter

Overview:
Parametrised, sequential successor to the team's 3-input gate-level ones counter. It latches a WIDTH-bit word on a start pulse and counts its ones (or zeros) over WIDTH/CHUNK clock cycles, processing CHUNK bits per cycle. It then presents the count with a one-cycle done pulse. It serves as the reusable population-count engine for datapath blocks that trade latency for area.

Parameters:
WIDTH, 8, input word width; legal range 2..64.
CHUNK, 1, bits consumed per cycle; must divide WIDTH exactly (elaboration-time check fails otherwise).
CW, $clog2(WIDTH+1), derived localparam giving the count width; not overridable.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst_n  input  1  synchronous, active-low reset.
start  input  1  request to begin a count; sampled only when busy=0.
din  input  WIDTH  data word; sampled on the accepted start cycle only.
mode  input  1  0 = count ones, 1 = count zeros; sampled with din.
busy  output  1  high while a count is in progress.
done  output  1  single-cycle pulse marking the cycle the result becomes valid.
count  output  CW  result of the last completed operation; held until the next done.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising clk edge.
- Reset values: state=IDLE, busy=0, done=0, count=0, and the internal shift register, accumulator and chunk counter all 0.
- States:
  - IDLE: busy=0. On start=1, latch din into shift_reg and latch mode, clear acc, load chunk_cnt=WIDTH/CHUNK-1, then go to COUNT.
  - COUNT: busy=1. Each cycle, acc += popcount(shift_reg[CHUNK-1:0] XOR {CHUNK{mode_q}}), then shift_reg >>= CHUNK.
    - If chunk_cnt==0, go to DONE; otherwise decrement chunk_cnt.
  - DONE: busy=0, done=1 for exactly this cycle, count <= acc (registered, visible in this cycle).
    - If start=1, perform the IDLE latch actions and go to COUNT (back-to-back); otherwise go to IDLE.
- Latency: start accepted at edge t gives done=1 in cycle t+WIDTH/CHUNK+1, i.e. 9 cycles for the defaults.
- Accepted-start throughput: one per WIDTH/CHUNK+1 cycles.
- start while busy=1 is ignored. din and mode changes during COUNT have no effect.
- count is stable between done pulses, including through a subsequent busy period.
- Arithmetic: acc is CW bits wide and never overflows (maximum value WIDTH). The per-chunk popcount is zero-extended to CW before the add.
- Reset during COUNT or DONE: the operation is aborted on that edge. The next cycle shows IDLE with busy=0, done=0 and count=0, and no done pulse is ever emitted for the aborted word.
- start asserted in the same cycle as rst_n=0: reset wins and start is dropped.
- Boundary values: din all-zero with mode=0 gives count=0; din all-ones with mode=0 gives count=WIDTH; mode=1 gives the complement of each (WIDTH minus the ones count).

Decomposition:
- Shared package ones_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_COUNT=2'd1, ST_DONE=2'd2;
  - a popcount width helper function, reused by other counting blocks.
- One combinational sub-module, chunk_popcount (parameter CHUNK; in: bits[CHUNK], invert; out: cnt[$clog2(CHUNK+1)]), counts ones in one chunk after an optional inversion.
- The top module holds the FSM, shift register, chunk counter and accumulator.

Test Plan:
1. Defaults; din=8'b0100_0000, mode=0, start pulsed at cycle 0 -> busy high cycles 1-8, done=1 at cycle 9, count=1.
2. Defaults; din=8'hFF, mode=0 -> count=8; then din=8'hFF, mode=1 -> count=0; then din=8'h00, mode=1 -> count=8.
3. Defaults; start at cycle 0 with din=8'h0F, then start held high and din=8'hFF during cycles 1-8 -> done at 9 with count=4 (later starts ignored). Start still high at cycle 9 -> new op latched with din=8'hFF, done at 18 with count=8.
4. Defaults; din=8'hB3, start at 0, rst_n=0 at cycle 4 -> cycle 5: busy=0, count=0; no done pulse through cycle 20.
5. WIDTH=8, CHUNK=4; din=8'hA5, mode=0 -> done at cycle 3, count=4; mode=1 on the next op -> count=4.
6. WIDTH=3, CHUNK=1; sweep all 8 values of din with mode=0 -> count matches the 3-input ones-count truth table (0,1,1,2,1,2,2,3), each done 4 cycles after its start.
